// File: rtl/swipt_pkg.sv
// Shared widths, constants and tracker state encoding for the SWIPT frequency loop.
package swipt_pkg;
   localparam int FW = 20;
   localparam int PW = 16;
   localparam logic [FW-1:0] F_START   = 20'd100000;
   localparam logic [PW-1:0] POWER_THR = 16'h0400;

   typedef enum logic [2:0] {
      IDLE, SETTLE, MEASURE, DECIDE, REQ, LATCH, DONE
   } tracker_state_t;
endpackage

// File: rtl/power_averager.sv
// Accumulates 2**AVG_LOG2 qualified power samples; avg is the truncated mean.
module power_averager #(
   parameter int PW       = 16,
   parameter int AVG_LOG2 = 3
)(
   input  logic          clk,
   input  logic          nrst,
   input  logic          clr,
   input  logic          valid,
   input  logic [PW-1:0] sample,
   output logic          done,
   output logic [PW-1:0] avg
);
   localparam int AW      = PW + AVG_LOG2;
   localparam int N_SMP_I = 1 << AVG_LOG2;
   localparam logic [AVG_LOG2:0] N_SMP = N_SMP_I[AVG_LOG2:0];

   logic [AW-1:0]     r_acc;
   logic [AVG_LOG2:0] r_cnt;

   assign done = (r_cnt == N_SMP);
   assign avg  = r_acc[AW-1:AVG_LOG2];

   // a sample arriving in the cycle the count is already full is discarded
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (clr) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (valid && !done) begin
         r_acc <= r_acc + AW'(sample);
         r_cnt <= r_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/freq_peak_tracker.sv
// Settle/measure/step FSM that hill-climbs link frequency and reports the power optimum.
// Optional window clamping is enabled by defining FREQ_LIMIT_EN.
module freq_peak_tracker
   import swipt_pkg::*;
#(
   parameter int SETTLE_CYC = 1024,
   parameter int AVG_LOG2   = 3,
   parameter int MAX_REV    = 4
`ifdef FREQ_LIMIT_EN
   ,
   parameter logic [FW-1:0] F_MIN = 20'd50000,
   parameter logic [FW-1:0] F_MAX = 20'd200000
`endif
)(
   input  logic          clk,
   input  logic          nrst,
   input  logic          swiptAlive,
   input  logic [FW-1:0] freq_new,
   input  logic [PW-1:0] power_sample,
   input  logic          power_valid,
   output logic [FW-1:0] freq,
   output logic          freq_rdy,
   output logic          freq_set_up_down,
   output logic          freq_optimum,
   output logic          power_optimum,
   output logic [FW-1:0] best_freq
);
   localparam int SCW = $clog2(SETTLE_CYC + 1);

   tracker_state_t r_state, w_state_nxt;
   logic [SCW-1:0] r_settle;
   logic [PW-1:0]  r_prev_pwr, r_best_pwr, w_avg;
   logic [3:0]     r_rev, w_rev_nxt;
   logic           r_first, r_dir, r_freq_rdy, r_fopt, r_popt;
   logic           w_improved, w_dir_nxt, w_rev_inc, w_better, w_done, w_clr, w_valid;
   logic [FW-1:0]  r_freq, r_best_freq, w_freq_in;

   assign w_clr   = (r_state == SETTLE) && (r_settle == '0);
   assign w_valid = (r_state == MEASURE) && power_valid;

   power_averager #(.PW(PW), .AVG_LOG2(AVG_LOG2)) u_avg (
      .clk    (clk),
      .nrst   (nrst),
      .clr    (w_clr),
      .valid  (w_valid),
      .sample (power_sample),
      .done   (w_done),
      .avg    (w_avg)
   );

   always_comb begin
      w_improved = r_first || (w_avg > r_prev_pwr);
      w_dir_nxt  = w_improved ? r_dir : ~r_dir;
      w_rev_inc  = ~w_improved;
`ifdef FREQ_LIMIT_EN
      // at a window edge the step must turn inward; that turn counts as a reversal
      if (w_dir_nxt && (r_freq >= F_MAX)) begin
         w_dir_nxt = 1'b0;
         w_rev_inc = 1'b1;
      end else if (!w_dir_nxt && (r_freq <= F_MIN)) begin
         w_dir_nxt = 1'b1;
         w_rev_inc = 1'b1;
      end
      if (freq_new > F_MAX)      w_freq_in = F_MAX;
      else if (freq_new < F_MIN) w_freq_in = F_MIN;
      else                       w_freq_in = freq_new;
`else
      w_freq_in = freq_new;
`endif
      w_rev_nxt = r_rev + {3'b000, w_rev_inc};
      w_better  = (w_avg > r_best_pwr);
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (swiptAlive) w_state_nxt = SETTLE;
         SETTLE:  if (r_settle == '0) w_state_nxt = MEASURE;
         MEASURE: if (w_done) w_state_nxt = DECIDE;
         DECIDE:  w_state_nxt = (w_rev_nxt >= 4'(MAX_REV)) ? DONE : REQ;
         REQ:     w_state_nxt = LATCH;
         LATCH:   w_state_nxt = SETTLE;
         DONE:    w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
      if (!swiptAlive) w_state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_settle    <= '0;
         r_prev_pwr  <= '0;
         r_best_pwr  <= '0;
         r_rev       <= '0;
         r_first     <= 1'b0;
         r_dir       <= 1'b1;
         r_freq_rdy  <= 1'b0;
         r_fopt      <= 1'b0;
         r_popt      <= 1'b0;
         r_freq      <= F_START;
         r_best_freq <= F_START;
      end else begin
         r_freq_rdy <= (w_state_nxt == REQ);
         r_fopt     <= (w_state_nxt == DONE);
         r_popt     <= swiptAlive && (r_state == DONE) && (r_best_pwr >= POWER_THR);
         if (!swiptAlive) begin
            r_rev   <= '0;
            r_first <= 1'b0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_settle    <= SCW'(SETTLE_CYC);
                  r_freq      <= F_START;
                  r_best_freq <= F_START;
                  r_best_pwr  <= '0;
                  r_prev_pwr  <= '0;
                  r_dir       <= 1'b1;
                  r_first     <= 1'b1;
                  r_rev       <= '0;
               end
               SETTLE: if (r_settle != '0) r_settle <= r_settle - 1'b1;
               DECIDE: begin
                  r_dir      <= w_dir_nxt;
                  r_rev      <= w_rev_nxt;
                  r_first    <= 1'b0;
                  r_prev_pwr <= w_avg;
                  if (w_better) begin
                     r_best_freq <= r_freq;
                     r_best_pwr  <= w_avg;
                  end
                  // best may be updated on this same edge, so pick the post-update value
                  if (w_state_nxt == DONE) r_freq <= w_better ? r_freq : r_best_freq;
               end
               LATCH: begin
                  r_freq   <= w_freq_in;
                  r_settle <= SCW'(SETTLE_CYC);
               end
               DONE:    r_freq <= r_best_freq;
               default: ;
            endcase
         end
      end
   end

   assign freq             = r_freq;
   assign freq_rdy         = r_freq_rdy;
   assign freq_set_up_down = r_dir;
   assign freq_optimum     = r_fopt;
   assign power_optimum    = r_popt;
   assign best_freq        = r_best_freq;
endmodule

// File: tb/tb_freq_peak_tracker.sv
// Directed bench: optimiser (+/-50 Hz) and power-vs-frequency models around freq_peak_tracker.
module tb_freq_peak_tracker;
   import swipt_pkg::*;

   logic          clk = 1'b0;
   logic          nrst, swiptAlive, power_valid;
   logic [FW-1:0] freq_new, freq, best_freq;
   logic [PW-1:0] power_sample;
   logic          freq_rdy, freq_set_up_down, freq_optimum, power_optimum;

   int            checks = 0;
   int            errors = 0;
   int            mode   = 0;
   logic [PW-1:0] peak   = 16'h0500;
   logic [1:0]    pv_cnt = 2'd0;
   logic          rdy_clr = 1'b0;
   int            rdy_cnt = 0;
   logic          bad_rdy = 1'b0;
   logic [FW-1:0] max_f = '0;
   bit            ok;

   always #5 clk = ~clk;

   freq_peak_tracker #(
      .SETTLE_CYC (16),
      .AVG_LOG2   (1),
      .MAX_REV    (2)
`ifdef FREQ_LIMIT_EN
      ,
      .F_MIN      (20'd50000),
      .F_MAX      (20'd100100)
`endif
   ) dut (
      .clk              (clk),
      .nrst             (nrst),
      .swiptAlive       (swiptAlive),
      .freq_new         (freq_new),
      .power_sample     (power_sample),
      .power_valid      (power_valid),
      .freq             (freq),
      .freq_rdy         (freq_rdy),
      .freq_set_up_down (freq_set_up_down),
      .freq_optimum     (freq_optimum),
      .power_optimum    (power_optimum),
      .best_freq        (best_freq)
   );

   function automatic logic [PW-1:0] pwr_of(input logic [FW-1:0] f);
      int d;
      logic [PW-1:0] p;
      d = int'(f) - int'(F_START);
      p = 16'h0010;
      case (mode)
         0: if (d >= 0 && d <= 1000) p = 16'(10 + (d / 50) * 10);
         1: begin
            if (d == 100)                 p = peak;
            else if (d == 50 || d == 150) p = peak - 16'h0100;
            else if (d == 0)              p = peak - 16'h0200;
         end
         default: p = 16'h0200;
      endcase
      return p;
   endfunction

   // optimiser model: registers the next step at the freq_rdy edge
   always @(posedge clk) begin
      if (freq_rdy) freq_new <= freq_set_up_down ? freq + 20'd50 : freq - 20'd50;
      pv_cnt       <= pv_cnt + 2'd1;
      power_valid  <= (pv_cnt == 2'd0);
      power_sample <= pwr_of(freq);
      if (rdy_clr) begin
         rdy_cnt <= 0;
         max_f   <= '0;
      end else begin
         if (freq_rdy) rdy_cnt <= rdy_cnt + 1;
         if (freq > max_f) max_f <= freq;
      end
      if (freq_rdy && freq_optimum) bad_rdy <= 1'b1;
   end

   task automatic wait_rdy(input int lim, output bit got);
      got = 1'b0;
      for (int i = 0; i < lim && !got; i++) begin
         @(posedge clk); #1;
         if (freq_rdy) got = 1'b1;
      end
   endtask

   task automatic wait_opt(input int lim, output bit got);
      got = 1'b0;
      for (int i = 0; i < lim && !got; i++) begin
         @(posedge clk); #1;
         if (freq_optimum) got = 1'b1;
      end
   endtask

   task automatic start(input int m);
      @(negedge clk);
      mode = m;
      rdy_clr = 1'b1;
      @(negedge clk);
      rdy_clr = 1'b0;
      swiptAlive = 1'b1;
   endtask

   task automatic stop();
      @(negedge clk);
      swiptAlive = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_reset();
      nrst = 1'b0; swiptAlive = 1'b0; freq_new = '0;
      power_valid = 1'b0; power_sample = '0;
      repeat (3) @(posedge clk); #1;
      checks++; if (freq !== F_START) begin errors++; $display("FAIL reset_freq got %0d exp %0d", freq, F_START); end
      checks++; if (best_freq !== F_START) begin errors++; $display("FAIL reset_best got %0d exp %0d", best_freq, F_START); end
      checks++; if ({freq_rdy, freq_set_up_down, freq_optimum, power_optimum} !== 4'b0100) begin
         errors++; $display("FAIL reset_flags got %b exp 0100", {freq_rdy, freq_set_up_down, freq_optimum, power_optimum}); end
      @(negedge clk); nrst = 1'b1;
   endtask

   task automatic test_reset_mid();
      start(0);
      wait_rdy(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got 0 exp 1"); end
      repeat (20) @(posedge clk);
      #3 nrst = 1'b0;
      #1;
      checks++; if (freq !== F_START) begin errors++; $display("FAIL rstmid_freq got %0d exp %0d", freq, F_START); end
      checks++; if ({freq_rdy, freq_optimum, power_optimum} !== 3'b000) begin
         errors++; $display("FAIL rstmid_flags got %b exp 000", {freq_rdy, freq_optimum, power_optimum}); end
      swiptAlive = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (freq !== F_START) begin errors++; $display("FAIL rstmid_hold%0d got %0d exp %0d", i, freq, F_START); end
      end
      @(negedge clk); nrst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_rising();
      logic [FW-1:0] exp_f;
      start(0);
      for (int s = 0; s < 3; s++) begin
         exp_f = F_START + 20'(50 * s);
         wait_rdy(300, ok);
         checks++;
         if (!ok) begin errors++; $display("FAIL rise_timeout%0d got 0 exp 1", s); end
         else begin
            if (freq !== exp_f) begin errors++; $display("FAIL rise_freq%0d got %0d exp %0d", s, freq, exp_f); end
            checks++; if (freq_set_up_down !== 1'b1) begin errors++; $display("FAIL rise_dir%0d got %b exp 1", s, freq_set_up_down); end
            checks++; if (best_freq !== exp_f) begin errors++; $display("FAIL rise_best%0d got %0d exp %0d", s, best_freq, exp_f); end
            @(posedge clk); #1;
            checks++; if (freq_rdy !== 1'b0) begin errors++; $display("FAIL rise_pulse%0d got %b exp 0", s, freq_rdy); end
         end
      end
      stop();
   endtask

   task automatic test_peak(input logic [PW-1:0] pk, input logic exp_popt);
      peak = pk;
      start(1);
      wait_opt(3000, ok);
      checks++; if (!ok) begin errors++; $display("FAIL peak_timeout got 0 exp 1"); end
      checks++; if (freq !== 20'd100100) begin errors++; $display("FAIL peak_freq got %0d exp 100100", freq); end
      checks++; if (best_freq !== 20'd100100) begin errors++; $display("FAIL peak_best got %0d exp 100100", best_freq); end
      checks++; if (rdy_cnt !== 5) begin errors++; $display("FAIL peak_rdycnt got %0d exp 5", rdy_cnt); end
      repeat (3) @(posedge clk); #1;
      checks++; if (power_optimum !== exp_popt) begin errors++; $display("FAIL peak_popt got %b exp %b", power_optimum, exp_popt); end
      checks++; if ({freq_rdy, freq_optimum} !== 2'b01) begin errors++; $display("FAIL peak_sticky got %b exp 01", {freq_rdy, freq_optimum}); end
      checks++; if (bad_rdy !== 1'b0) begin errors++; $display("FAIL peak_rdy_in_opt got %b exp 0", bad_rdy); end
   endtask

   task automatic test_tie();
      start(2);
      wait_rdy(300, ok);
      checks++; if (!ok || freq !== F_START || freq_set_up_down !== 1'b1) begin
         errors++; $display("FAIL tie_first got ok=%b f=%0d dir=%b exp 1 %0d 1", ok, freq, freq_set_up_down, F_START); end
      wait_rdy(300, ok);
      checks++; if (!ok || freq !== 20'd100050 || freq_set_up_down !== 1'b0) begin
         errors++; $display("FAIL tie_toggle got ok=%b f=%0d dir=%b exp 1 100050 0", ok, freq, freq_set_up_down); end
      wait_opt(300, ok);
      checks++; if (!ok || freq !== F_START) begin errors++; $display("FAIL tie_done got ok=%b f=%0d exp 1 %0d", ok, freq, F_START); end
      repeat (3) @(posedge clk); #1;
      checks++; if (power_optimum !== 1'b0) begin errors++; $display("FAIL tie_popt got %b exp 0", power_optimum); end
      stop();
   endtask

   task automatic test_done_drop();
      @(negedge clk); swiptAlive = 1'b0;
      @(posedge clk); #1;
      checks++; if ({freq_optimum, power_optimum} !== 2'b00) begin
         errors++; $display("FAIL drop_flags got %b exp 00", {freq_optimum, power_optimum}); end
      checks++; if (freq !== 20'd100100 || best_freq !== 20'd100100) begin
         errors++; $display("FAIL drop_hold got f=%0d b=%0d exp 100100", freq, best_freq); end
      repeat (2) @(posedge clk);
      start(0);
      wait_rdy(300, ok);
      checks++; if (!ok || freq !== F_START || freq_set_up_down !== 1'b1 || best_freq !== F_START) begin
         errors++; $display("FAIL drop_restart got ok=%b f=%0d dir=%b b=%0d exp 1 %0d 1 %0d",
                            ok, freq, freq_set_up_down, best_freq, F_START, F_START); end
      stop();
   endtask

`ifdef FREQ_LIMIT_EN
   task automatic test_limit();
      start(0);
      for (int s = 0; s < 3; s++) wait_rdy(300, ok);
      checks++; if (!ok || freq !== 20'd100100 || freq_set_up_down !== 1'b0) begin
         errors++; $display("FAIL lim_force got ok=%b f=%0d dir=%b exp 1 100100 0", ok, freq, freq_set_up_down); end
      wait_opt(500, ok);
      checks++; if (!ok || freq !== 20'd100100) begin errors++; $display("FAIL lim_done got ok=%b f=%0d exp 1 100100", ok, freq); end
      checks++; if (max_f > 20'd100100) begin errors++; $display("FAIL lim_max got %0d exp <=100100", max_f); end
      stop();
   endtask
`endif

   initial begin
      test_reset();
      test_reset_mid();
      test_rising();
      test_peak(16'h0300, 1'b0);
      stop();
      test_tie();
      test_peak(16'h0500, 1'b1);
      test_done_drop();
`ifdef FREQ_LIMIT_EN
      test_limit();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
